// File: rtl/cam_ctrl_pkg.sv
// Shared types for the CAM front-end controller: CAM command, request opcode,
// controller state encoding and the response record.
package cam_ctrl_pkg;

    typedef enum logic {READ = 1'b0, WRITE = 1'b1} COMMAND;

    typedef enum logic {OP_LOOKUP = 1'b0, OP_INSERT = 1'b1} REQ_OP;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LOOKUP = 3'd1;
    localparam logic [2:0] ST_CHECK  = 3'd2;
    localparam logic [2:0] ST_WRITE  = 3'd3;
    localparam logic [2:0] ST_RESP   = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE   = ST_IDLE,
        S_LOOKUP = ST_LOOKUP,
        S_CHECK  = ST_CHECK,
        S_WRITE  = ST_WRITE,
        S_RESP   = ST_RESP
    } CTRL_STATE;

    // Fields sized for the largest supported configuration; the top slices them.
    localparam int unsigned RESP_IDX_W = 16;
    localparam int unsigned RESP_ID_W  = 8;

    typedef struct packed {
        logic                  hit;
        logic [RESP_IDX_W-1:0] idx;
        logic                  evict;
        logic [RESP_ID_W-1:0]  id;
    } resp_t;

endpackage

// File: rtl/cam_ctrl_rr_arbiter.sv
// Round-robin arbiter: one-hot grant searching from last_grant+1 with wrap,
// last_grant advancing only when a grant is accepted.
module rr_arbiter #(
    parameter int NUM_REQ = 2
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         valid,
    input  logic                       enable,
    input  logic                       accept,
    output logic [NUM_REQ-1:0]         grant,
    output logic [$clog2(NUM_REQ)-1:0] grant_id
);
    localparam int RW = $clog2(NUM_REQ);

    logic [RW-1:0] last_grant;

    always_comb begin
        int unsigned k;
        logic        found;
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        k        = 0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            k = (32'(last_grant) + i) % NUM_REQ;
            if (enable && !found && valid[k]) begin
                found    = 1'b1;
                grant[k] = 1'b1;
                grant_id = RW'(k);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            last_grant <= RW'(NUM_REQ - 1);
        end else if (accept) begin
            last_grant <= grant_id;
        end
    end

endmodule

// File: rtl/cam_ctrl.sv
// Shares one CAM among NUM_REQ requesters: arbitrates, sequences lookup/insert
// onto the CAM port, allocates write slots (fill then round-robin eviction).
module cam_ctrl
    import cam_ctrl_pkg::*;
#(
    parameter int SIZE    = 8,
    parameter int NUM_REQ = 2
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ-1:0]           req_op,
    input  logic [NUM_REQ-1:0][31:0]     req_data,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic                         resp_valid,
    output logic [$clog2(NUM_REQ)-1:0]   resp_id,
    output logic                         resp_hit,
    output logic [$clog2(SIZE)-1:0]      resp_idx,
    output logic                         resp_evict,
    output logic [$clog2(SIZE+1)-1:0]    occupancy,
    output logic                         full,
    output logic                         cam_enable,
    output logic                         cam_command,
    output logic [31:0]                  cam_data,
    output logic [$clog2(SIZE)-1:0]      cam_write_idx,
    input  logic                         cam_hit,
    input  logic [$clog2(SIZE)-1:0]      cam_read_idx
);
    localparam int IW = $clog2(SIZE);
    localparam int RW = $clog2(NUM_REQ);
    localparam int OW = $clog2(SIZE + 1);

    CTRL_STATE     state;
    REQ_OP         op_q;
    logic [31:0]   key_q;
    logic [RW-1:0] id_q;
    logic [OW-1:0] occ;
    logic [IW-1:0] victim;
    resp_t         resp_q;
    logic [RW-1:0] grant_id;
    logic          accept;
    logic [IW-1:0] write_idx;
    logic          unused_resp_bits;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .clock    (clock),
        .reset    (reset),
        .valid    (req_valid),
        .enable   (state == S_IDLE),
        .accept   (accept),
        .grant    (req_ready),
        .grant_id (grant_id)
    );

    assign accept    = |(req_valid & req_ready);
    assign full      = (occ == OW'(SIZE));
    // occ < SIZE whenever it is used as an index, so the slot stays in range.
    assign write_idx = full ? victim : IW'(occ);

    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= S_IDLE;
            op_q   <= OP_LOOKUP;
            key_q  <= '0;
            id_q   <= '0;
            occ    <= '0;
            victim <= '0;
            resp_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        op_q  <= REQ_OP'(req_op[grant_id]);
                        key_q <= req_data[grant_id];
                        id_q  <= grant_id;
                        state <= S_LOOKUP;
                    end
                end
                S_LOOKUP: state <= S_CHECK;
                S_CHECK: begin
                    if (cam_hit) begin
                        resp_q <= '{hit: 1'b1, idx: RESP_IDX_W'(cam_read_idx),
                                    evict: 1'b0, id: RESP_ID_W'(id_q)};
                        state  <= S_RESP;
                    end else if (op_q == OP_INSERT) begin
                        state <= S_WRITE;
                    end else begin
                        resp_q <= '{hit: 1'b0, idx: '0, evict: 1'b0, id: RESP_ID_W'(id_q)};
                        state  <= S_RESP;
                    end
                end
                S_WRITE: begin
                    resp_q <= '{hit: 1'b0, idx: RESP_IDX_W'(write_idx),
                                evict: full, id: RESP_ID_W'(id_q)};
                    if (!full) begin
                        occ <= occ + OW'(1);
                    end else begin
                        victim <= (victim == IW'(SIZE - 1)) ? '0 : victim + IW'(1);
                    end
                    state <= S_RESP;
                end
                S_RESP:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        cam_enable    = (state == S_LOOKUP) || (state == S_CHECK) || (state == S_WRITE);
        cam_command   = (state == S_WRITE) ? WRITE : READ;
        cam_data      = cam_enable ? key_q : '0;
        cam_write_idx = (state == S_WRITE) ? write_idx : '0;
    end

    assign resp_valid       = (state == S_RESP);
    assign resp_hit         = resp_q.hit;
    assign resp_idx         = resp_q.idx[IW-1:0];
    assign resp_evict       = resp_q.evict;
    assign resp_id          = resp_q.id[RW-1:0];
    assign occupancy        = occ;
    assign unused_resp_bits = ^{resp_q.idx, resp_q.id};

endmodule

// File: tb/tb_cam_ctrl.sv
// Directed bench for cam_ctrl with behavioural CAMs beside an 8-entry and a
// 5-entry controller instance.
module tb_cam_ctrl;
    import cam_ctrl_pkg::*;

    logic clock = 1'b0;
    always #5 clock = ~clock;
    logic reset;

    logic [1:0]       req_valid, req_op, req_ready;
    logic [1:0][31:0] req_data;
    logic             resp_valid, resp_hit, resp_evict, full, cam_enable, cam_command, cam_hit;
    logic [0:0]       resp_id;
    logic [2:0]       resp_idx, cam_write_idx, cam_read_idx;
    logic [3:0]       occupancy;
    logic [31:0]      cam_data;

    logic [1:0]       r5_valid, r5_op, r5_ready;
    logic [1:0][31:0] r5_data;
    logic             r5_resp_valid, r5_hit, r5_evict, r5_full, c5_enable, c5_command, c5_hit;
    logic [0:0]       r5_id;
    logic [2:0]       r5_idx, r5_occ, c5_widx, c5_ridx;
    logic [31:0]      c5_data;

    cam_ctrl #(.SIZE(8), .NUM_REQ(2)) dut (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_op(req_op),
        .req_data(req_data), .req_ready(req_ready), .resp_valid(resp_valid),
        .resp_id(resp_id), .resp_hit(resp_hit), .resp_idx(resp_idx),
        .resp_evict(resp_evict), .occupancy(occupancy), .full(full),
        .cam_enable(cam_enable), .cam_command(cam_command), .cam_data(cam_data),
        .cam_write_idx(cam_write_idx), .cam_hit(cam_hit), .cam_read_idx(cam_read_idx)
    );

    cam_ctrl #(.SIZE(5), .NUM_REQ(2)) dut5 (
        .clock(clock), .reset(reset), .req_valid(r5_valid), .req_op(r5_op),
        .req_data(r5_data), .req_ready(r5_ready), .resp_valid(r5_resp_valid),
        .resp_id(r5_id), .resp_hit(r5_hit), .resp_idx(r5_idx),
        .resp_evict(r5_evict), .occupancy(r5_occ), .full(r5_full),
        .cam_enable(c5_enable), .cam_command(c5_command), .cam_data(c5_data),
        .cam_write_idx(c5_widx), .cam_hit(c5_hit), .cam_read_idx(c5_ridx)
    );

    // Behavioural CAMs: cleared by reset, lowest matching entry wins.
    logic [31:0] mk [8];
    logic [7:0]  mv;
    logic [31:0] mk5 [5];
    logic [4:0]  mv5;

    always @(posedge clock) begin
        if (reset) mv <= '0;
        else if (cam_enable && cam_command == WRITE) begin
            mk[cam_write_idx] <= cam_data;
            mv[cam_write_idx] <= 1'b1;
        end
        if (reset) mv5 <= '0;
        else if (c5_enable && c5_command == WRITE && c5_widx < 3'd5) begin
            mk5[c5_widx] <= c5_data;
            mv5[c5_widx] <= 1'b1;
        end
    end

    always_comb begin
        cam_hit = 1'b0; cam_read_idx = '0;
        for (int i = 7; i >= 0; i--)
            if (mv[i] && mk[i] == cam_data) begin cam_hit = 1'b1; cam_read_idx = 3'(i); end
        c5_hit = 1'b0; c5_ridx = '0;
        for (int i = 4; i >= 0; i--)
            if (mv5[i] && mk5[i] == c5_data) begin c5_hit = 1'b1; c5_ridx = 3'(i); end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    int ready_viol = 0;
    int max_w5     = 0;
    always @(negedge clock) begin
        if (!$onehot0(req_ready) || !$onehot0(r5_ready)) ready_viol++;
        if (c5_enable && c5_command == WRITE && int'(c5_widx) > max_w5) max_w5 = int'(c5_widx);
    end

    logic        r_hit, r_evict;
    logic [31:0] r_idx, r_id;
    int          lat;

    task automatic txn(input int id, input logic op, input logic [31:0] key);
        int w;
        @(negedge clock);
        req_valid[id] = 1'b1; req_op[id] = op; req_data[id] = key;
        #1;
        w = 0;
        while (!req_ready[id] && w < 20) begin @(negedge clock); #1; w++; end
        if (!req_ready[id]) begin
            check_eq("grant_timeout", 32'(req_ready[id]), 1);
            req_valid[id] = 1'b0; lat = -1;
            return;
        end
        @(posedge clock); #1;
        req_valid[id] = 1'b0; req_data[id] = ~key; req_op[id] = ~op;
        lat = -1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clock);
            if (resp_valid) begin
                lat = c; r_hit = resp_hit; r_idx = 32'(resp_idx);
                r_evict = resp_evict; r_id = 32'(resp_id);
                break;
            end
        end
        if (lat > 0) begin
            @(negedge clock);
            check_eq("resp_pulse_one_cycle", 32'(resp_valid), 0);
            check_eq("resp_idx_held", 32'(resp_idx), r_idx);
        end
    endtask

    task automatic txn5(input logic [31:0] key);
        int w;
        @(negedge clock);
        r5_valid[0] = 1'b1; r5_op[0] = OP_INSERT; r5_data[0] = key;
        #1;
        w = 0;
        while (!r5_ready[0] && w < 20) begin @(negedge clock); #1; w++; end
        @(posedge clock); #1;
        r5_valid[0] = 1'b0;
        lat = -1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clock);
            if (r5_resp_valid) begin
                lat = c; r_idx = 32'(r5_idx); r_evict = r5_evict; r_hit = r5_hit;
                break;
            end
        end
    endtask

    task automatic pulse_reset();
        @(negedge clock); reset = 1'b1;
        @(negedge clock); reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int seen, w;
        reset = 1'b1;
        req_valid = '0; req_op = '0; req_data = '0;
        r5_valid = '0; r5_op = '0; r5_data = '0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check_eq("rst_resp_valid", 32'(resp_valid), 0);
        check_eq("rst_occupancy", 32'(occupancy), 0);
        check_eq("rst_full", 32'(full), 0);
        check_eq("rst_cam_enable", 32'(cam_enable), 0);
        check_eq("rst_cam_command", 32'(cam_command), 32'(READ));
        check_eq("rst_resp_fields", {29'd0, resp_hit, resp_evict, resp_id}, 0);

        txn(0, OP_LOOKUP, 32'h5);
        check_eq("lk5_latency", lat, 3);
        check_eq("lk5_hit", 32'(r_hit), 0);
        check_eq("lk5_idx", r_idx, 0);
        check_eq("lk5_id", r_id, 0);
        check_eq("lk5_occ", 32'(occupancy), 0);

        for (int i = 0; i < 8; i++) begin
            txn(0, OP_INSERT, 32'(i));
            check_eq($sformatf("ins%0d_latency", i), lat, 4);
            check_eq($sformatf("ins%0d_idx", i), r_idx, 32'(i));
            check_eq($sformatf("ins%0d_evict", i), 32'(r_evict), 0);
            check_eq($sformatf("ins%0d_hit", i), 32'(r_hit), 0);
        end
        check_eq("fill_occ", 32'(occupancy), 8);
        check_eq("fill_full", 32'(full), 1);

        txn(0, OP_INSERT, 32'h3);
        check_eq("dup3_latency", lat, 3);
        check_eq("dup3_hit", 32'(r_hit), 1);
        check_eq("dup3_idx", r_idx, 3);
        check_eq("dup3_occ", 32'(occupancy), 8);

        txn(0, OP_INSERT, 32'h100);
        check_eq("ev100_latency", lat, 4);
        check_eq("ev100_idx", r_idx, 0);
        check_eq("ev100_evict", 32'(r_evict), 1);
        txn(0, OP_INSERT, 32'h101);
        check_eq("ev101_idx", r_idx, 1);
        check_eq("ev101_evict", 32'(r_evict), 1);
        txn(0, OP_LOOKUP, 32'h0);
        check_eq("lk0_after_evict_hit", 32'(r_hit), 0);
        txn(0, OP_LOOKUP, 32'h100);
        check_eq("lk100_hit", 32'(r_hit), 1);
        check_eq("lk100_idx", r_idx, 0);
        txn(0, OP_LOOKUP, 32'h2);
        check_eq("lk2_hit", 32'(r_hit), 1);
        check_eq("lk2_idx", r_idx, 2);

        pulse_reset();
        req_op = {OP_LOOKUP, OP_LOOKUP};
        req_data[0] = 32'hA; req_data[1] = 32'hB;
        req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            w = 0;
            do begin @(negedge clock); w++; end while (!resp_valid && w < 10);
            check_eq($sformatf("rr%0d_resp_id", k), 32'(resp_id), 32'(k % 2));
            check_eq($sformatf("rr%0d_hit", k), 32'(resp_hit), 0);
        end
        req_valid = 2'b00;
        repeat (2) @(negedge clock);

        txn(0, OP_INSERT, 32'h55);
        check_eq("ins55_idx", r_idx, 0);
        check_eq("ins55_occ", 32'(occupancy), 1);
        @(negedge clock);
        req_valid[0] = 1'b1; req_op[0] = OP_INSERT; req_data[0] = 32'h777;
        #1;
        w = 0;
        while (!req_ready[0] && w < 20) begin @(negedge clock); #1; w++; end
        @(posedge clock); #1;
        req_valid[0] = 1'b0;
        w = 0;
        do begin @(negedge clock); w++; end while (cam_command != WRITE && w < 10);
        check_eq("reached_write", 32'(cam_command), 32'(WRITE));
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        seen = 0;
        repeat (5) begin @(negedge clock); if (resp_valid) seen++; end
        check_eq("midrst_no_resp", seen, 0);
        check_eq("midrst_occ", 32'(occupancy), 0);
        check_eq("midrst_full", 32'(full), 0);
        txn(0, OP_LOOKUP, 32'h777);
        check_eq("midrst_lk777_hit", 32'(r_hit), 0);
        txn(0, OP_LOOKUP, 32'h55);
        check_eq("midrst_lk55_hit", 32'(r_hit), 0);

        for (int i = 0; i < 9; i++) begin
            txn5(32'h200 + 32'(i));
            check_eq($sformatf("s5_ins%0d_latency", i), lat, 4);
            check_eq($sformatf("s5_ins%0d_idx", i), r_idx, 32'((i < 5) ? i : i - 5));
            check_eq($sformatf("s5_ins%0d_evict", i), 32'(r_evict), 32'(i >= 5));
        end
        check_eq("s5_full", 32'(r5_full), 1);
        check_eq("s5_occ", 32'(r5_occ), 5);
        check_eq("s5_write_idx_max", max_w5, 4);
        check_eq("ready_onehot0", ready_viol, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cam_ctrl.md
Name: cam_ctrl

Overview:
Front-end controller that shares one CAM instance (SIZE entries, 32-bit keys) among NUM_REQ requesters.
- Arbitrates requests round-robin.
- Sequences each accepted request onto the CAM's enable/command/data/write_idx interface.
- For INSERT misses, allocates an entry index: fill first, then round-robin eviction.
- Returns one response per request on a shared response port.

Parameters:
SIZE, 8, number of CAM entries; any value >= 2, need not be a power of two.
NUM_REQ, 2, number of requesters; must be >= 2.

Ports:
clock  in  1  system clock.
reset  in  1  synchronous, active-high reset. It is also routed to the CAM.
req_valid  in  NUM_REQ  per-requester request valid.
req_op  in  NUM_REQ x REQ_OP  per-requester operation: OP_LOOKUP or OP_INSERT.
req_data  in  NUM_REQ x 32  per-requester key.
req_ready  out  NUM_REQ  one-hot grant; at most one bit high.
resp_valid  out  1  one-cycle response pulse.
resp_id  out  $clog2(NUM_REQ)  requester that owns the response.
resp_hit  out  1  key was already present.
resp_idx  out  $clog2(SIZE)  index found, or index written.
resp_evict  out  1  INSERT overwrote a live entry.
occupancy  out  $clog2(SIZE+1)  number of entries written since reset, saturating at SIZE.
full  out  1  occupancy == SIZE.
cam_enable  out  1  CAM enable.
cam_command  out  COMMAND  CAM command: READ or WRITE.
cam_data  out  32  CAM key.
cam_write_idx  out  $clog2(SIZE)  CAM write index.
cam_hit  in  1  CAM match flag.
cam_read_idx  in  $clog2(SIZE)  CAM match index (lowest matching entry).

Behaviour:
- FSM states: IDLE, LOOKUP, CHECK, WRITE, RESP.
- Reset values:
  - State IDLE.
  - All outputs 0; cam_command = READ.
  - occupancy = 0, victim pointer = 0.
  - Arbiter last_grant = NUM_REQ-1, so requester 0 wins first.
- IDLE:
  - req_ready is high only in IDLE, and only for the round-robin winner among valid requesters.
  - Search starts at last_grant+1 and wraps.
  - req_ready is combinational from req_valid and last_grant.
  - Handshake is req_valid & req_ready. On handshake: latch op, data and id; update last_grant; go to LOOKUP.
  - With no valid requests, stay in IDLE.
- LOOKUP: cam_enable=1, cam_command=READ, cam_data=latched key. Go to CHECK.
- CHECK:
  - Drive the same outputs as LOOKUP; hold cam_data stable.
  - Sample cam_hit/cam_read_idx at the end of the cycle.
  - If hit (either op): resp_hit=1, resp_idx=cam_read_idx, go to RESP.
  - If OP_LOOKUP miss: resp_hit=0, resp_idx=0, go to RESP.
  - If OP_INSERT miss: go to WRITE.
- WRITE:
  - cam_enable=1, cam_command=WRITE, cam_data=key.
  - If !full: cam_write_idx = occupancy; occupancy += 1; resp_evict=0.
  - Else: cam_write_idx = victim; victim = (victim == SIZE-1) ? 0 : victim+1; resp_evict=1.
  - resp_idx = written index. Go to RESP.
- RESP: resp_valid=1 for exactly one cycle with resp_id; cam_enable=0. Go to IDLE.
- Latency: handshake in cycle t.
  - LOOKUP, or INSERT that hits: resp_valid in cycle t+3.
  - INSERT that misses: resp_valid in cycle t+4.
  - Next handshake no earlier than the cycle after RESP.
- Write index bounds: write indices are never >= SIZE, even when $clog2(SIZE) allows more.
- Victim pointer: wraps at SIZE-1 and advances only on eviction.
- cam_enable is 0 in IDLE and RESP. cam_command returns to READ outside WRITE.
- Response fields hold their value until the next response.
- Reset mid-operation: the in-flight request is dropped, no resp_valid is issued, and every register takes its reset value. The CAM is cleared by the same reset.
- req_valid deasserted after a handshake has no effect on the latched request.

Decomposition:
- Shared package holds:
  - Existing COMMAND enum {READ, WRITE}.
  - New REQ_OP enum {OP_LOOKUP, OP_INSERT}.
  - CTRL_STATE enum.
  - A resp_t struct {hit, idx, evict, id}.
- One natural sub-module: rr_arbiter (NUM_REQ-way, one-hot grant, last_grant register, update on accept).
- CAM is instantiated beside cam_ctrl, not inside it.

Test Plan:
- Reset, then requester 0 issues OP_LOOKUP key 32'h5 → resp_valid at t+3, resp_hit=0, occupancy=0.
- Insert keys 0..7 (SIZE=8) from requester 0 → each resp_idx = i, resp_evict=0, resp at t+4; then full=1, occupancy=8.
- Insert an existing key 32'h3 → resp_hit=1, resp_idx=3 at t+3; no WRITE cycle, occupancy unchanged.
- Full CAM, insert new keys 32'h100, 32'h101 → resp_idx 0 then 1, resp_evict=1; lookup 32'h0 misses; lookup 32'h100 hits at idx 0.
- Both requesters hold req_valid continuously → grants alternate 0,1,0,1; resp_id matches; req_ready never high for both.
- Assert reset during WRITE state → no resp_valid, occupancy=0, and a following lookup of that key misses.
- SIZE=5: nine inserts of distinct keys → indices 0,1,2,3,4,0,1,2,3; cam_write_idx never exceeds 4.
